axis_uncompress_b1: RTL and testbench

Second-generation AXI-stream address expander. Each compressed command beat {wrap, step, addr, len} is expanded into len+1 output beats carrying addresses addr, addr+step, addr+2·step, … with optional wrap inside an aligned window. It sits between a descriptor/record source and a RAM read port, as the address generator feeding RAM-to-stream paths. Compared with the first-generation expander it adds a runtime step, window wrap, zero-bubble back-to-back commands and first/last beat flags.

---
 rtl/axis_uncompress_b1_if.sv | 29 ++
 rtl/axis_uncompress_b1.sv | 103 ++++++++++
 tb/tb_axis_uncompress_b1.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_uncompress_b1_if.sv
// Stream bundle for the address expander: compressed command stream in,
// expanded address stream out. The slave modport is the expander's view.
interface axis_uncompress_b1_if #(
    parameter int ASIZE = 8,
    parameter int LSIZE = 8,
    parameter int SSIZE = 8
);
    localparam int CW = 1 + SSIZE + ASIZE + LSIZE;

    logic [CW-1:0]    s_tdata;
    logic             s_tvalid;
    logic             s_tready;
    logic             s_tlast;
    logic [ASIZE-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic [1:0]       m_tuser;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast, m_tuser
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast, m_tuser
    );
endinterface

// File: rtl/axis_uncompress_b1.sv
// Address expander: each command {wrap, step, addr, len} becomes len+1 address
// beats addr, addr+step, ... with optional wrap inside a 2^WBITS window.
//
// state | meaning
// IDLE  | no beat held, m_tvalid low, ready for a command
// BURST | a beat is on m_tdata; rem_q beats follow it
module axis_uncompress_b1 #(
    parameter int ASIZE = 8,
    parameter int LSIZE = 8,
    parameter int SSIZE = 8,
    parameter int WBITS = 4
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  clken,
    axis_uncompress_b1_if.slave   bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [ASIZE-1:0] WMASK = {ASIZE{1'b1}} >> (ASIZE - WBITS);

    state_t           state_q;
    logic [ASIZE-1:0] addr_q;
    logic [LSIZE-1:0] rem_q;
    logic [SSIZE-1:0] step_q;
    logic             wrap_q;
    logic             rec_last_q;
    logic             first_q;

    logic             cmd_wrap;
    logic [SSIZE-1:0] cmd_step;
    logic [ASIZE-1:0] cmd_addr;
    logic [LSIZE-1:0] cmd_len;
    logic             rem_zero;
    logic             s_tready_w;
    logic             accept;
    logic             beat_done;
    logic [ASIZE-1:0] sum_d;
    logic [ASIZE-1:0] next_addr_d;

    assign cmd_len  = bus.s_tdata[LSIZE-1:0];
    assign cmd_addr = bus.s_tdata[LSIZE+ASIZE-1:LSIZE];
    assign cmd_step = bus.s_tdata[LSIZE+ASIZE+SSIZE-1:LSIZE+ASIZE];
    assign cmd_wrap = bus.s_tdata[LSIZE+ASIZE+SSIZE];

    assign rem_zero = (rem_q == '0);

    // Ready looks straight through m_tready so the next command loads in the
    // cycle the current last beat leaves: no bubble between commands.
    assign s_tready_w = clken && ((state_q == IDLE) || (bus.m_tready && rem_zero));
    assign accept     = bus.s_tvalid && s_tready_w;
    assign beat_done  = (state_q == BURST) && bus.m_tready && clken;

    // Next address: full-width add, or only the window bits advance when wrapping.
    always_comb begin
        sum_d       = addr_q + ASIZE'(step_q);
        next_addr_d = sum_d;
        if (wrap_q) begin
            next_addr_d = (addr_q & ~WMASK) | (sum_d & WMASK);
        end
    end

    // Burst sequencer: load on accept, advance per handshake, idle after the last beat.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            step_q     <= '0;
            wrap_q     <= 1'b0;
            rec_last_q <= 1'b0;
            first_q    <= 1'b0;
        end else if (clken) begin
            if (accept) begin
                state_q    <= BURST;
                addr_q     <= cmd_addr;
                rem_q      <= cmd_len;
                step_q     <= cmd_step;
                wrap_q     <= cmd_wrap;
                rec_last_q <= bus.s_tlast;
                first_q    <= 1'b1;
            end else if (beat_done) begin
                first_q <= 1'b0;
                if (!rem_zero) begin
                    rem_q  <= rem_q - 1'b1;
                    addr_q <= next_addr_d;
                end else begin
                    state_q <= IDLE;
                end
            end
        end
    end

    // Flags are gated by valid so an idle output presents all zeros.
    assign bus.s_tready = s_tready_w;
    assign bus.m_tvalid = (state_q == BURST);
    assign bus.m_tdata  = addr_q;
    assign bus.m_tuser  = {(state_q == BURST) && rem_zero, first_q};
    assign bus.m_tlast  = (state_q == BURST) && rem_zero && rec_last_q;
endmodule

// File: tb/tb_axis_uncompress_b1.sv
// Bench for axis_uncompress_b1: directed and randomized command streams checked
// against a beat-list model computed from the address-expansion rules.
module tb_axis_uncompress_b1;
    localparam int ASIZE = 8;
    localparam int LSIZE = 8;
    localparam int SSIZE = 8;
    localparam int WBITS = 4;
    localparam int CW    = 1 + SSIZE + ASIZE + LSIZE;
    localparam int AMOD  = 2 ** ASIZE;
    localparam int WMOD  = 2 ** WBITS;

    typedef struct {
        logic             wrap;
        logic [SSIZE-1:0] step;
        logic [ASIZE-1:0] addr;
        logic [LSIZE-1:0] len;
        logic             last;
    } cmd_t;

    logic clock = 1'b0;
    logic rst_n;
    logic clken;

    axis_uncompress_b1_if #(.ASIZE(ASIZE), .LSIZE(LSIZE), .SSIZE(SSIZE)) bus ();

    axis_uncompress_b1 #(.ASIZE(ASIZE), .LSIZE(LSIZE), .SSIZE(SSIZE), .WBITS(WBITS)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .clken (clken),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;

    cmd_t             cq[$];
    logic [ASIZE-1:0] exp_addr[$];
    logic [1:0]       exp_user[$];
    logic             exp_last[$];
    logic [ASIZE-1:0] obs_addr[$];
    logic [1:0]       obs_user[$];
    logic             obs_last[$];
    logic             obs_sready[$];
    int               obs_cyc[$];
    int               acc_cyc[$];
    bit               timed_out;
    int               stall_errs;

    logic [ASIZE-1:0] o_data;
    logic [1:0]       o_user;
    logic             o_valid, o_last, o_sready;
    logic             acc_s, beat_s;

    function automatic logic [CW-1:0] pack(input cmd_t c);
        return {c.wrap, c.step, c.addr, c.len};
    endfunction

    task automatic clear_model();
        cq.delete();
        exp_addr.delete();
        exp_user.delete();
        exp_last.delete();
    endtask

    // Reference: list every beat a command must produce.
    task automatic add_cmd(input cmd_t c);
        int a;
        int n;
        a = int'(c.addr);
        n = int'(c.len);
        cq.push_back(c);
        for (int i = 0; i <= n; i++) begin
            exp_addr.push_back(ASIZE'(a));
            exp_user.push_back({i == n, i == 0});
            exp_last.push_back((i == n) && c.last);
            if (c.wrap)
                a = (a / WMOD) * WMOD + ((a % WMOD + int'(c.step) % WMOD) % WMOD);
            else
                a = (a + int'(c.step)) % AMOD;
        end
    endtask

    function automatic cmd_t mk(input logic w, input int s, input int a, input int l, input logic lst);
        cmd_t c;
        c.wrap = w;
        c.step = SSIZE'(s);
        c.addr = ASIZE'(a);
        c.len  = LSIZE'(l);
        c.last = lst;
        return c;
    endfunction

    // One clock: drive at negedge, sample just after, then pass the rising edge.
    task automatic step_cycle(input logic v, input logic [CW-1:0] d, input logic l,
                              input logic rdy, input logic ce);
        @(negedge clock);
        bus.s_tvalid = v;
        bus.s_tdata  = d;
        bus.s_tlast  = l;
        bus.m_tready = rdy;
        clken        = ce;
        #1;
        o_valid  = bus.m_tvalid;
        o_data   = bus.m_tdata;
        o_user   = bus.m_tuser;
        o_last   = bus.m_tlast;
        o_sready = bus.s_tready;
        acc_s    = v && o_sready;
        beat_s   = o_valid && rdy && ce;
        @(posedge clock);
    endtask

    // Feed cq to the DUT and record every output handshake.
    task automatic run_stream(input int rdy_pct, input int ce_pct, input int gap_pct, input int max_cyc);
        bit               presenting;
        bit               hold;
        logic [ASIZE-1:0] p_data;
        logic [1:0]       p_user;
        logic             p_last;
        logic             rdy, ce;
        logic [CW-1:0]    d;
        logic             l;
        int               drain;
        int               cyc;
        presenting = 0; hold = 0; drain = 0; cyc = 0;
        p_data = '0; p_user = '0; p_last = 1'b0;
        obs_addr.delete(); obs_user.delete(); obs_last.delete();
        obs_sready.delete(); obs_cyc.delete(); acc_cyc.delete();
        timed_out = 0;
        stall_errs = 0;
        while (drain < 4) begin
            if (cyc >= max_cyc) begin
                timed_out = 1;
                break;
            end
            if (cq.size() == 0 && obs_addr.size() >= exp_addr.size()) begin
                drain++;
                rdy = 1'b1;
                ce  = 1'b1;
            end else begin
                rdy = ($urandom_range(0, 99) < rdy_pct);
                ce  = ($urandom_range(0, 99) < ce_pct);
            end
            if (!presenting && cq.size() > 0)
                presenting = ($urandom_range(0, 99) >= gap_pct);
            d = '0;
            l = 1'b0;
            if (presenting) begin
                d = pack(cq[0]);
                l = cq[0].last;
            end
            step_cycle(presenting, d, l, rdy, ce);
            if (hold && (o_valid !== 1'b1 || o_data !== p_data || o_user !== p_user || o_last !== p_last))
                stall_errs++;
            hold   = o_valid && !beat_s;
            p_data = o_data;
            p_user = o_user;
            p_last = o_last;
            if (acc_s) begin
                cq.pop_front();
                presenting = 0;
                acc_cyc.push_back(cyc);
            end
            if (beat_s) begin
                obs_addr.push_back(o_data);
                obs_user.push_back(o_user);
                obs_last.push_back(o_last);
                obs_sready.push_back(o_sready);
                obs_cyc.push_back(cyc);
            end
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clken = 1'b1;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.s_tlast  = 1'b0;
        bus.m_tready = 1'b0;
        #1;
        tests_run++; if (bus.m_tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b want 0", bus.m_tvalid); end
        tests_run++; if (bus.m_tdata !== '0) begin tests_failed++; $display("FAIL reset_tdata: got %h want 00", bus.m_tdata); end
        tests_run++; if (bus.m_tlast !== 1'b0) begin tests_failed++; $display("FAIL reset_tlast: got %b want 0", bus.m_tlast); end
        tests_run++; if (bus.m_tuser !== 2'b00) begin tests_failed++; $display("FAIL reset_tuser: got %b want 00", bus.m_tuser); end
        tests_run++; if (bus.s_tready !== 1'b1) begin tests_failed++; $display("FAIL reset_sready_ce1: got %b want 1", bus.s_tready); end
        clken = 1'b0;
        #1;
        tests_run++; if (bus.s_tready !== 1'b0) begin tests_failed++; $display("FAIL reset_sready_ce0: got %b want 0", bus.s_tready); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        clken = 1'b1;
    endtask

    task automatic test_basic();
        clear_model();
        add_cmd(mk(1'b0, 1, 8'h10, 3, 1'b1));
        run_stream(100, 100, 0, 100);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL basic_timeout: got 1 want 0"); end
        tests_run++; if (obs_addr.size() != exp_addr.size()) begin tests_failed++; $display("FAIL basic_count: got %0d want %0d", obs_addr.size(), exp_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            tests_run++; if (obs_addr[i] !== exp_addr[i]) begin tests_failed++; $display("FAIL basic_addr[%0d]: got %h want %h", i, obs_addr[i], exp_addr[i]); end
            tests_run++; if (obs_user[i] !== exp_user[i]) begin tests_failed++; $display("FAIL basic_user[%0d]: got %b want %b", i, obs_user[i], exp_user[i]); end
            tests_run++; if (obs_last[i] !== exp_last[i]) begin tests_failed++; $display("FAIL basic_last[%0d]: got %b want %b", i, obs_last[i], exp_last[i]); end
            tests_run++; if (obs_cyc[i] != obs_cyc[0] + i) begin tests_failed++; $display("FAIL basic_consecutive[%0d]: got cycle %0d want %0d", i, obs_cyc[i], obs_cyc[0] + i); end
        end
        if (acc_cyc.size() > 0 && obs_cyc.size() > 0) begin
            tests_run++; if (obs_cyc[0] != acc_cyc[0] + 1) begin tests_failed++; $display("FAIL basic_latency: got %0d want %0d", obs_cyc[0] - acc_cyc[0], 1); end
        end
    endtask

    task automatic test_step_wrap();
        for (int k = 0; k < 2; k++) begin
            clear_model();
            if (k == 0) add_cmd(mk(1'b0, 8'h40, 8'hC0, 2, 1'b0));
            else        add_cmd(mk(1'b1, 3, 8'h2D, 3, 1'b1));
            run_stream(100, 100, 0, 100);
            tests_run++; if (timed_out) begin tests_failed++; $display("FAIL stepwrap%0d_timeout: got 1 want 0", k); end
            tests_run++; if (obs_addr.size() != exp_addr.size()) begin tests_failed++; $display("FAIL stepwrap%0d_count: got %0d want %0d", k, obs_addr.size(), exp_addr.size()); end
            for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
                tests_run++; if (obs_addr[i] !== exp_addr[i]) begin tests_failed++; $display("FAIL stepwrap%0d_addr[%0d]: got %h want %h", k, i, obs_addr[i], exp_addr[i]); end
                tests_run++; if (obs_user[i] !== exp_user[i] || obs_last[i] !== exp_last[i]) begin tests_failed++; $display("FAIL stepwrap%0d_flags[%0d]: got %b/%b want %b/%b", k, i, obs_user[i], obs_last[i], exp_user[i], exp_last[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_model();
        add_cmd(mk(1'b0, 1, 8'h00, 0, 1'b0));
        add_cmd(mk(1'b0, 1, 8'h20, 0, 1'b0));
        add_cmd(mk(1'b0, 5, 8'h30, 1, 1'b1));
        run_stream(100, 100, 0, 100);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL b2b_timeout: got 1 want 0"); end
        tests_run++; if (obs_addr.size() != 4) begin tests_failed++; $display("FAIL b2b_count: got %0d want 4", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            tests_run++; if (obs_addr[i] !== exp_addr[i]) begin tests_failed++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, obs_addr[i], exp_addr[i]); end
            tests_run++; if (obs_user[i] !== exp_user[i]) begin tests_failed++; $display("FAIL b2b_user[%0d]: got %b want %b", i, obs_user[i], exp_user[i]); end
            tests_run++; if (obs_cyc[i] != obs_cyc[0] + i) begin tests_failed++; $display("FAIL b2b_consecutive[%0d]: got cycle %0d want %0d", i, obs_cyc[i], obs_cyc[0] + i); end
            if (exp_user[i][1]) begin
                tests_run++; if (obs_sready[i] !== 1'b1) begin tests_failed++; $display("FAIL b2b_sready_on_last[%0d]: got %b want 1", i, obs_sready[i]); end
            end
        end
    endtask

    task automatic test_random();
        int s;
        clear_model();
        for (int n = 0; n < 40; n++) begin
            s = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, AMOD - 1));
            add_cmd(mk(1'($urandom_range(0, 1)), s, int'($urandom_range(0, AMOD - 1)),
                       int'($urandom_range(0, 6)), 1'($urandom_range(0, 1))));
        end
        run_stream(60, 75, 30, 4000);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL rand_timeout: got 1 want 0"); end
        tests_run++; if (stall_errs != 0) begin tests_failed++; $display("FAIL rand_stall_stable: got %0d changes want 0", stall_errs); end
        tests_run++; if (obs_addr.size() != exp_addr.size()) begin tests_failed++; $display("FAIL rand_count: got %0d want %0d", obs_addr.size(), exp_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            tests_run++;
            if (obs_addr[i] !== exp_addr[i] || obs_user[i] !== exp_user[i] || obs_last[i] !== exp_last[i]) begin
                tests_failed++;
                $display("FAIL rand_beat[%0d]: got %h/%b/%b want %h/%b/%b", i, obs_addr[i], obs_user[i], obs_last[i], exp_addr[i], exp_user[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int beats;
        int cyc;
        clear_model();
        cq.push_back(mk(1'b0, 1, 8'h50, 7, 1'b1));
        beats = 0;
        cyc = 0;
        while (beats < 3 && cyc < 50) begin
            if (cq.size() > 0) step_cycle(1'b1, pack(cq[0]), cq[0].last, 1'b1, 1'b1);
            else               step_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
            if (acc_s) cq.pop_front();
            if (beat_s) beats++;
            cyc++;
        end
        tests_run++; if (beats != 3) begin tests_failed++; $display("FAIL rstmid_prebeats: got %0d want 3", beats); end
        @(negedge clock);
        rst_n = 1'b0;
        #1;
        tests_run++; if (bus.m_tvalid !== 1'b0 || bus.m_tdata !== '0 || bus.m_tuser !== 2'b00 || bus.m_tlast !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: got v=%b d=%h u=%b l=%b want all 0", bus.m_tvalid, bus.m_tdata, bus.m_tuser, bus.m_tlast);
        end
        @(negedge clock);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
            tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_beat[%0d]: got %b want 0", i, o_valid); end
        end
        clear_model();
        add_cmd(mk(1'b0, 2, 8'h70, 1, 1'b0));
        run_stream(100, 100, 0, 100);
        tests_run++; if (obs_addr.size() != exp_addr.size()) begin tests_failed++; $display("FAIL rstmid_count: got %0d want %0d", obs_addr.size(), exp_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            tests_run++; if (obs_addr[i] !== exp_addr[i] || obs_user[i] !== exp_user[i]) begin tests_failed++; $display("FAIL rstmid_beat[%0d]: got %h/%b want %h/%b", i, obs_addr[i], obs_user[i], exp_addr[i], exp_user[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_step_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
